// File: rtl/io_po_if.sv
// Peripheral output handshake: show-ahead head of the output FIFO, with a ready back-pressure signal.
interface io_po_if #(
  parameter int unsigned NUBITS = 16,
  parameter int unsigned NBIOOU = 2
);
  logic [NUBITS-1:0] po_data;
  logic [NBIOOU-1:0] po_addr;
  logic              po_valid;
  logic              po_ready;

  modport master (output po_data, output po_addr, output po_valid, input po_ready);
  modport slave  (input po_data, input po_addr, input po_valid, output po_ready);
endinterface

// File: rtl/io_fifo.sv
// Synchronous show-ahead FIFO; dout shows the head entry and reads as zero while empty.
module io_fifo #(
  parameter int unsigned NBDATA = 18,
  parameter int unsigned FDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [NBDATA-1:0]        din,
  output logic [NBDATA-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(FDEPTH):0]  level
);
  localparam int unsigned PW = $clog2(FDEPTH);
  localparam int unsigned LW = PW + 1;

  logic [NBDATA-1:0] mem [FDEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic              do_push, do_pop;

  assign full    = (lvl_q == LW'(FDEPTH));
  assign empty   = (lvl_q == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign level   = lvl_q;
  assign dout    = empty ? '0 : mem[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end
endmodule

// File: rtl/io_ctrl.sv
// I/O controller: buffered output writes to peripherals, per-port input holding registers
// with fresh flags, and a registered interrupt on writes to masked input ports.
module io_ctrl #(
  parameter int unsigned            NUBITS = 16,
  parameter int unsigned            NBIOIN = 2,
  parameter int unsigned            NBIOOU = 2,
  parameter int unsigned            FDEPTH = 4,
  parameter logic [2**NBIOIN-1:0]   ITRMSK = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUBITS-1:0]        cpu_dout,
  input  logic [NBIOOU-1:0]        cpu_aout,
  input  logic                     cpu_oen,
  input  logic [NBIOIN-1:0]        cpu_ain,
  input  logic                     cpu_req,
  output logic [NUBITS-1:0]        cpu_din,
  output logic                     cpu_itr,
  io_po_if.master                  po,
  input  logic [NUBITS-1:0]        pi_data,
  input  logic [NBIOIN-1:0]        pi_addr,
  input  logic                     pi_valid,
  output logic [2**NBIOIN-1:0]     pi_fresh,
  output logic [$clog2(FDEPTH):0]  fifo_lvl,
  output logic                     ovf
);
  localparam int unsigned NIN = 2**NBIOIN;

  logic [NBIOOU+NUBITS-1:0] fifo_dout;
  logic                     fifo_full, fifo_empty, fifo_pop;

  logic [NUBITS-1:0] hold_q [NIN];
  logic [NUBITS-1:0] hold_d [NIN];
  logic [NIN-1:0]    fresh_q, fresh_d;
  logic              itr_q, itr_d;
  logic              ovf_q, ovf_d;

  assign fifo_pop = ~fifo_empty & po.po_ready;

  io_fifo #(
    .NBDATA (NBIOOU + NUBITS),
    .FDEPTH (FDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu_oen),
    .pop   (fifo_pop),
    .din   ({cpu_aout, cpu_dout}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_lvl)
  );

  assign {po.po_addr, po.po_data} = fifo_dout;
  assign po.po_valid = ~fifo_empty;

  assign cpu_din  = hold_q[cpu_ain];
  assign pi_fresh = fresh_q;
  assign cpu_itr  = itr_q;
  assign ovf      = ovf_q;

  always_comb begin
    hold_d  = hold_q;
    fresh_d = fresh_q;
    // Clear first so a same-port peripheral write in this cycle leaves the flag set.
    if (cpu_req) fresh_d[cpu_ain] = 1'b0;
    if (pi_valid) begin
      hold_d[pi_addr]  = pi_data;
      fresh_d[pi_addr] = 1'b1;
    end
    itr_d = pi_valid & ITRMSK[pi_addr];
    ovf_d = ovf_q | (cpu_oen & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NIN; i++) hold_q[i] <= '0;
      fresh_q <= '0;
      itr_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      fresh_q <= fresh_d;
      itr_q   <= itr_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
